// File: rtl/usr_pkg.sv
// Shared types for the universal shift register: operation encoding,
// burst FSM states and the shift-mode classifier.
package usr_pkg;

    typedef enum logic [2:0] {
        M_HOLD  = 3'd0,
        M_LOAD  = 3'd1,
        M_SHL   = 3'd2,
        M_SHR   = 3'd3,
        M_ROL   = 3'd4,
        M_ROR   = 3'd5,
        M_ASR   = 3'd6,
        M_CLEAR = 3'd7
    } mode_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Only shift/rotate modes can be repeated as a burst.
    function automatic logic is_shift(input mode_t m);
        return (m == M_SHL) || (m == M_SHR) || (m == M_ROL) ||
               (m == M_ROR) || (m == M_ASR);
    endfunction

endpackage

// File: rtl/usr_burst_ctrl.sv
// Burst controller: decides which op the datapath applies on each edge and
// whether it applies one at all. Owns the IDLE/RUN FSM, remaining count and
// latched burst op, plus busy/done generation.
module usr_burst_ctrl
    import usr_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  mode_t            mode,
    input  logic             start,
    input  logic [CNT_W-1:0] shift_cnt,
    output mode_t            op_eff,
    output logic             step,
    output logic             busy,
    output logic             done
);

    state_t           state, state_n;
    logic [CNT_W-1:0] rem, rem_n;
    mode_t            op_q, op_n;
    logic             done_n;

    // State, count and latched op; done is cleared every edge so it pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            rem   <= '0;
            op_q  <= M_HOLD;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            rem   <= rem_n;
            op_q  <= op_n;
            done  <= done_n;
        end
    end

    // Next state and datapath strobe; RUN ignores mode/start entirely.
    always_comb begin
        state_n = state;
        rem_n   = rem;
        op_n    = op_q;
        done_n  = 1'b0;
        step    = 1'b0;
        op_eff  = mode;
        case (state)
            IDLE: begin
                if (en) begin
                    if (start && is_shift(mode)) begin
                        // Accept edge: latch only, q does not move yet.
                        op_n  = mode;
                        rem_n = shift_cnt;
                        if (shift_cnt != '0) state_n = RUN;
                        else                 done_n  = 1'b1;
                    end else begin
                        step = 1'b1;
                    end
                end
            end
            RUN: begin
                op_eff = op_q;
                if (en) begin
                    step  = 1'b1;
                    rem_n = rem - CNT_W'(1);
                    if (rem == CNT_W'(1)) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign busy = (state == RUN);

endmodule

// File: rtl/universal_shift_reg.sv
// Universal shift register: WIDTH-bit storage with load/clear/shift/rotate
// single steps and a counted burst of one shift op under start/busy/done.
module universal_shift_reg
    import usr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_l,
    input  logic             sin_r,
    input  logic             start,
    input  logic [CNT_W-1:0] shift_cnt,
    output logic [WIDTH-1:0] q,
    output logic             sout_l,
    output logic             sout_r,
    output logic             busy,
    output logic             done
);

    mode_t            op_eff;
    logic             step;
    logic [WIDTH-1:0] q_next;

    usr_burst_ctrl #(.CNT_W(CNT_W)) u_ctrl (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .mode      (mode_t'(mode)),
        .start     (start),
        .shift_cnt (shift_cnt),
        .op_eff    (op_eff),
        .step      (step),
        .busy      (busy),
        .done      (done)
    );

    // Next-value mux; serial inputs are taken live on every shift edge.
    always_comb begin
        q_next = q;
        case (op_eff)
            M_HOLD:  q_next = q;
            M_LOAD:  q_next = d;
            M_SHL:   q_next = {q[WIDTH-2:0], sin_r};
            M_SHR:   q_next = {sin_l, q[WIDTH-1:1]};
            M_ROL:   q_next = {q[WIDTH-2:0], q[WIDTH-1]};
            M_ROR:   q_next = {q[0], q[WIDTH-1:1]};
            M_ASR:   q_next = {q[WIDTH-1], q[WIDTH-1:1]};
            M_CLEAR: q_next = '0;
            default: q_next = q;
        endcase
    end

    // Storage register, updated only on strobed edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       q <= '0;
        else if (step) q <= q_next;
    end

    assign sout_l = q[WIDTH-1];
    assign sout_r = q[0];

endmodule
